oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter LEN, default 160: number of bytes per transfer (1..256).
REQ-002 SHALL have parameter BYTE_CYCLES, default 4: clocks per byte slot (>= 2).
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-clock request pulse (CPU write to FF46).
REQ-006 SHALL have port src_page  input  8  source high byte, sampled when start=1.
REQ-007 SHALL have port rd_en  output  1  read-request strobe to the synchronous-read memory bus.
REQ-008 SHALL have port rd_addr  output  16  read address; memory returns rd_data on the following clock.
REQ-009 SHALL have port rd_data  input  8  registered read data, valid exactly one clock after rd_en.
REQ-010 SHALL have port oam_we  output  1  OAM write strobe.
REQ-011 SHALL have port oam_addr  output  8  OAM byte index.
REQ-012 SHALL have port oam_wdata  output  8  OAM write data.
REQ-013 SHALL have port busy  output  1  transfer in progress; CPU bus arbitration uses it.

Function
REQ-014 SHALL implement states IDLE, SETUP, XFER; slot counter counts 0..BYTE_CYCLES-1, byte index i counts 0..LEN-1.
REQ-015 IDLE + start=1 SHALL latch the page, clear i and the slot counter, and enter SETUP on the next clock.
REQ-016 SETUP SHALL last exactly BYTE_CYCLES clocks with rd_en=0 and oam_we=0, then enter XFER.
REQ-017 XFER, slot 0: SHALL drive rd_en=1 and rd_addr={page,i} for exactly one clock.
REQ-018 XFER, slot 1: SHALL drive oam_we=1, oam_addr=i, oam_wdata=rd_data (data pass-through, no extra register) for exactly one clock.
REQ-019 End of slot BYTE_CYCLES-1: SHALL increment i; after i=LEN-1 the block SHALL return to IDLE.
REQ-020 busy SHALL be 1 in SETUP and XFER, 0 in IDLE; it is high for exactly (LEN+1)*BYTE_CYCLES clocks per uninterrupted transfer.
REQ-021 start=1 while busy SHALL restart: latch the new page, clear i and the slot counter, enter SETUP; any pending slot-1 write from the aborted slot SHALL be dropped.
REQ-022 rd_addr SHALL be 16'h0000 and oam_addr/oam_wdata SHALL be 0 whenever the matching strobe is 0.
REQ-023 The index counter SHALL be 8 bits; LEN=256 SHALL terminate by the state check, not by overflow.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, page=0, i=0, slot=0, and busy=rd_en=oam_we=0, including mid-transfer; no partial write SHALL occur after release.
REQ-025 After rst rises, the first start SHALL be accepted on the first rising clock edge.

Configuration
REQ-026 With OAM_DMA_ECHO_EN defined, a latched page >= 8'hE0 SHALL be remapped to page-8'h20 (echo RAM onto work RAM); without it, the page SHALL be used unmodified.

Structure
REQ-027 The state enum and the OAM_BASE constant (16'hFE00, for the top-level decode) SHALL live in the shared CPU package with the register-file indices.
REQ-028 No sub-module; single always_ff plus output always_comb.

Verification
REQ-029 src_page=8'hC0, LEN=160, BYTE_CYCLES=4: rd_addr sweeps C000..C09F; 160 oam_we pulses with oam_addr 0..159; busy is high for 644 clocks.
REQ-030 Memory preloaded with mem[C000+k]=k^8'h5A: OAM model contents equal k^8'h5A for k=0..159; each write occurs exactly one clock after its rd_en.
REQ-031 Restart with page C1 issued during byte 50 of a C0 transfer: no write of index 50; the next rd_addr after SETUP is C100; the final OAM holds C1xx data.
REQ-032 rst=0 asserted mid-clock during byte 10: busy, rd_en and oam_we drop without a clock edge; no strobes follow until the next start.
REQ-033 src_page=8'hFE with OAM_DMA_ECHO_EN defined: first rd_addr=DE00; without the macro: first rd_addr=FE00.
REQ-034 LEN=256, BYTE_CYCLES=2: 256 writes, last oam_addr=8'hFF, busy drops after 514 clocks, no wrap to index 0.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared CPU package: DMA state encoding, OAM/DMA register decode constants
// and the source-page mapping helper.
// Optional build macro: OAM_DMA_ECHO_EN remaps echo-RAM pages (>= E0) onto work RAM.
package oam_dma_pkg;

    localparam int unsigned PAGE_W = 8;
    localparam int unsigned IDX_W  = 8;

    // Top-level address decode constants and register-file indices.
    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam logic [15:0] REG_DMA  = 16'hFF46;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2
    } dma_state_e;

    // Source page actually used for a transfer.
    function automatic logic [PAGE_W-1:0] map_page(input logic [PAGE_W-1:0] p);
`ifdef OAM_DMA_ECHO_EN
        return (p >= 8'hE0) ? PAGE_W'(p - 8'h20) : p;
`else
        return p;
`endif
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies LEN bytes from {page,00..} into OAM, one byte per
// BYTE_CYCLES-clock slot after a one-slot setup period.
// Ports:
//   clk, rst (async, active-low)
//   start, src_page         - CPU request pulse and source high byte
//   rd_en, rd_addr, rd_data - synchronous-read memory bus (data one clock later)
//   oam_we, oam_addr, oam_wdata - OAM write port (data passes straight from rd_data)
//   busy                    - transfer in progress
// Optional build macro: OAM_DMA_ECHO_EN (see oam_dma_pkg::map_page).
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int unsigned LEN         = 160,
    parameter int unsigned BYTE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PAGE_W-1:0]    src_page,
    output logic                 rd_en,
    output logic [15:0]          rd_addr,
    input  logic [7:0]           rd_data,
    output logic                 oam_we,
    output logic [IDX_W-1:0]     oam_addr,
    output logic [7:0]           oam_wdata,
    output logic                 busy
);

    localparam int unsigned      SLOT_W    = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BYTE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(LEN - 1);

    dma_state_e        state_q, state_d;
    logic [PAGE_W-1:0] page_q,  page_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [SLOT_W-1:0] slot_q,  slot_d;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            page_q  <= '0;
            idx_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
        end
    end

    // Next state and strobes; strobes decode from current state so reset clears them at once.
    always_comb begin
        state_d   = state_q;
        page_d    = page_q;
        idx_d     = idx_q;
        slot_d    = slot_q;
        busy      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = 16'h0000;
        oam_we    = 1'b0;
        oam_addr  = '0;
        oam_wdata = 8'h00;

        case (state_q)
            ST_IDLE: begin
            end
            ST_SETUP: begin
                busy = 1'b1;
                if (slot_q == SLOT_LAST) begin
                    slot_d  = '0;
                    state_d = ST_XFER;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            ST_XFER: begin
                busy = 1'b1;
                if (slot_q == '0) begin
                    rd_en   = 1'b1;
                    rd_addr = {page_q, idx_q};
                end
                if (slot_q == SLOT_W'(1)) begin
                    oam_we    = 1'b1;
                    oam_addr  = idx_q;
                    oam_wdata = rd_data;
                end
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    // Terminate on the index compare so LEN=256 never wraps.
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request in any state restarts; the aborted slot's write never happens.
        if (start) begin
            state_d = ST_SETUP;
            page_d  = map_page(src_page);
            idx_d   = '0;
            slot_d  = '0;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: instance 0 uses LEN=160/BYTE_CYCLES=4, instance 1 uses
// LEN=256/BYTE_CYCLES=2. Expected outputs come from a cycle-count model.
module tb_oam_dma;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v   [2];
    logic [7:0] page_v    [2];
    logic       rd_en_v   [2];
    logic [15:0] rd_addr_v [2];
    logic [7:0] rd_data_v [2];
    logic       oam_we_v  [2];
    logic [7:0] oam_addr_v [2];
    logic [7:0] oam_wdata_v [2];
    logic       busy_v    [2];

    always #5 clk = ~clk;

    oam_dma dut_a (
        .clk(clk), .rst(rst_n), .start(start_v[0]), .src_page(page_v[0]),
        .rd_en(rd_en_v[0]), .rd_addr(rd_addr_v[0]), .rd_data(rd_data_v[0]),
        .oam_we(oam_we_v[0]), .oam_addr(oam_addr_v[0]), .oam_wdata(oam_wdata_v[0]),
        .busy(busy_v[0])
    );

    oam_dma #(.LEN(256), .BYTE_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst_n), .start(start_v[1]), .src_page(page_v[1]),
        .rd_en(rd_en_v[1]), .rd_addr(rd_addr_v[1]), .rd_data(rd_data_v[1]),
        .oam_we(oam_we_v[1]), .oam_addr(oam_addr_v[1]), .oam_wdata(oam_wdata_v[1]),
        .busy(busy_v[1])
    );

    int n_assert = 0;
    int n_fail   = 0;

    function automatic int len_of(input int d);
        return (d == 0) ? 160 : 256;
    endfunction

    function automatic int bc_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic logic [7:0] mem_val(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
    endfunction

    function automatic logic [7:0] exp_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_EN
        if (p >= 8'hE0) return p - 8'h20;
`endif
        return p;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Synchronous-read memory and OAM images.
    logic [7:0] oam_m [2][256];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd_en_v[d] === 1'b1) rd_data_v[d] <= mem_val(rd_addr_v[d]);
            if (oam_we_v[d] === 1'b1) oam_m[d][oam_addr_v[d]] <= oam_wdata_v[d];
        end
    end

    // Model: clocks elapsed since the accepted request, plus the mapped page.
    bit       m_act  [2] = '{1'b0, 1'b0};
    int       m_cyc  [2] = '{0, 0};
    bit [7:0] m_page [2] = '{8'h00, 8'h00};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d] = 1'b0;
                m_cyc[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (start_v[d] === 1'b1) begin
                    m_act[d]  = 1'b1;
                    m_cyc[d]  = 0;
                    m_page[d] = exp_page(page_v[d]);
                end else if (m_act[d]) begin
                    m_cyc[d]++;
                    if (m_cyc[d] >= (len_of(d) + 1) * bc_of(d)) m_act[d] = 1'b0;
                end
            end
        end
    end

    // Statistics gathered alongside the per-cycle compare.
    int          busy_cnt [2];
    int          rd_cnt   [2];
    int          we_cnt   [2];
    bit          seen_rd  [2];
    logic [15:0] first_rd [2];
    logic [15:0] last_rd  [2];
    logic [7:0]  last_oam [2];
    logic        prev_rd  [2] = '{1'b0, 1'b0};
    logic [15:0] prev_addr [2];

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0; rd_cnt[d] = 0; we_cnt[d] = 0; seen_rd[d] = 1'b0;
            first_rd[d] = 16'h0; last_rd[d] = 16'h0; last_oam[d] = 8'h0;
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int       c, bc, slot, byt;
        bit       inx, rde, wee;
        logic [15:0] ea;
        for (int d = 0; d < 2; d++) begin
            c    = m_cyc[d];
            bc   = bc_of(d);
            slot = c % bc;
            byt  = c / bc - 1;
            inx  = m_act[d] && (c >= bc);
            rde  = inx && (slot == 0);
            wee  = inx && (slot == 1);
            ea   = {m_page[d], 8'(byt)};
            chk("busy",      d, 32'(busy_v[d]),   32'(m_act[d]));
            chk("rd_en",     d, 32'(rd_en_v[d]),  32'(rde));
            chk("rd_addr",   d, 32'(rd_addr_v[d]), rde ? 32'(ea) : 32'h0);
            chk("oam_we",    d, 32'(oam_we_v[d]), 32'(wee));
            chk("oam_addr",  d, 32'(oam_addr_v[d]), wee ? 32'(ea[7:0]) : 32'h0);
            chk("oam_wdata", d, 32'(oam_wdata_v[d]), wee ? 32'(mem_val(ea)) : 32'h0);

            if (busy_v[d] === 1'b1) busy_cnt[d]++;
            if (rd_en_v[d] === 1'b1) begin
                rd_cnt[d]++;
                if (!seen_rd[d]) first_rd[d] = rd_addr_v[d];
                seen_rd[d] = 1'b1;
                last_rd[d] = rd_addr_v[d];
            end
            if (oam_we_v[d] === 1'b1) begin
                we_cnt[d]++;
                last_oam[d] = oam_addr_v[d];
                chk("wr_after_rd", d, 32'(prev_rd[d]), 32'h1);
                chk("wr_idx_of_rd", d, 32'(oam_addr_v[d]), 32'(prev_addr[d][7:0]));
            end
            prev_rd[d]   = rd_en_v[d];
            prev_addr[d] = rd_addr_v[d];
        end
    end

    task automatic pulse(input int d, input logic [7:0] p);
        @(posedge clk); #1;
        start_v[d] = 1'b1; page_v[d] = p;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (busy_v[0] !== 1'b1 && busy_v[1] !== 1'b1) break;
        end
        chk("wait_idle", 0, 32'(busy_v[0] | busy_v[1]), 32'h0);
    endtask

    task automatic wait_rd(input int d, input logic [15:0] a, input int budget);
        bit found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (rd_en_v[d] === 1'b1 && rd_addr_v[d] == a) found = 1'b1;
        end
        chk("wait_rd", d, 32'(found), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin start_v[d] = 1'b0; page_v[d] = 8'h00; end
        clear_stats();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy",  d, 32'(busy_v[d]),   32'h0);
            chk("reset_rd_en", d, 32'(rd_en_v[d]),  32'h0);
            chk("reset_we",    d, 32'(oam_we_v[d]), 32'h0);
        end

        // Full transfers from C0 on both instances; start accepted on the first edge after release.
        @(negedge clk);
        start_v[0] = 1'b1; page_v[0] = 8'hC0;
        start_v[1] = 1'b1; page_v[1] = 8'hC0;
        rst_n = 1'b1;
        clear_stats();
        @(posedge clk); #1;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        chk("first_start_accept", 0, 32'(busy_v[0]), 32'h1);
        wait_idle(2000);
        chk("busy_clocks",  0, 32'(busy_cnt[0]), 32'd644);
        chk("write_count",  0, 32'(we_cnt[0]),   32'd160);
        chk("read_count",   0, 32'(rd_cnt[0]),   32'd160);
        chk("first_rd",     0, 32'(first_rd[0]), 32'hC000);
        chk("last_rd",      0, 32'(last_rd[0]),  32'hC09F);
        chk("last_oam",     0, 32'(last_oam[0]), 32'd159);
        chk("busy_clocks",  1, 32'(busy_cnt[1]), 32'd514);
        chk("write_count",  1, 32'(we_cnt[1]),   32'd256);
        chk("last_oam",     1, 32'(last_oam[1]), 32'hFF);
        chk("last_rd",      1, 32'(last_rd[1]),  32'hC0FF);
        for (int k = 0; k < 160; k++) chk("oam_c0", 0, 32'(oam_m[0][k]), 32'(8'(k) ^ 8'h5A));
        for (int k = 0; k < 256; k++) chk("oam_c0", 1, 32'(oam_m[1][k]), 32'(8'(k) ^ 8'h5A));

        // Restart with C1 during the read slot of byte 50.
        pulse(0, 8'hC0);
        wait_rd(0, 16'hC032, 1000);
        start_v[0] = 1'b1; page_v[0] = 8'hC1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        clear_stats();
        wait_idle(2000);
        chk("restart_writes", 0, 32'(we_cnt[0]),   32'd160);
        chk("restart_first",  0, 32'(first_rd[0]), 32'hC100);
        chk("restart_busy",   0, 32'(busy_cnt[0]), 32'd644);
        for (int k = 0; k < 160; k++) chk("oam_c1", 0, 32'(oam_m[0][k]), 32'(8'(k) ^ 8'h5B));

        // Asynchronous reset in the middle of a clock during byte 10.
        pulse(0, 8'hC0);
        wait_rd(0, 16'hC00A, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy",  0, 32'(busy_v[0]),   32'h0);
        chk("async_rst_rd_en", 0, 32'(rd_en_v[0]),  32'h0);
        chk("async_rst_we",    0, 32'(oam_we_v[0]), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        clear_stats();
        repeat (60) @(negedge clk);
        chk("post_rst_busy",   0, 32'(busy_cnt[0]), 32'h0);
        chk("post_rst_reads",  0, 32'(rd_cnt[0]),   32'h0);
        chk("post_rst_writes", 0, 32'(we_cnt[0]),   32'h0);

        // Echo-page source.
        clear_stats();
        pulse(0, 8'hFE);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            found = seen_rd[0];
        end
`ifdef OAM_DMA_ECHO_EN
        chk("echo_first_rd", 0, 32'(first_rd[0]), 32'hDE00);
`else
        chk("echo_first_rd", 0, 32'(first_rd[0]), 32'hFE00);
`endif
        wait_idle(2000);

        // Random requests, restarts and mid-cycle resets.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(posedge clk); #3 rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 rst_n = 1'b1;
            end else begin
                @(posedge clk); #1;
                for (int d = 0; d < 2; d++) begin
                    start_v[d] = 1'($urandom_range(0, 1));
                    page_v[d]  = 8'($urandom);
                end
                @(posedge clk); #1;
                start_v[0] = 1'b0; start_v[1] = 1'b0;
            end
            repeat ($urandom_range(0, 800)) @(posedge clk);
        end
        wait_idle(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
